// File: rtl/sleep_req_ctl_pkg.sv
// Shared encodings for the sleep request sequencer: FSM states, wake causes
// and the minimum release hold that covers the distribution block's pipeline.
package sleep_req_ctl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_ASLEEP  = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [1:0] WC_CORE    = 2'b00;
    localparam logic [1:0] WC_AGENT   = 2'b01;
    localparam logic [1:0] WC_TIMER   = 2'b10;
    localparam logic [1:0] WC_DISABLE = 2'b11;

    localparam int unsigned RELEASE_MIN_CYC = 3;

endpackage

// File: rtl/sleep_wake_timer.sv
// Auto-wake down-counter: loads on sleep entry, decrements when enabled and
// saturates at zero so a long sleep can never wrap into a huge delay.
module sleep_wake_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/sleep_req_ctl.sv
// Gathers agent sleep requests, raises EXT_SLEEPREQ_R once all unmasked agents
// have requested stably, acknowledges at system sleep and releases on wake.
module sleep_req_ctl
    import sleep_req_ctl_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic             SYSCLKF,
    input  logic             RESET_D2_R_N,
    input  logic             CFG_SLEEPENABLE,
    input  logic [NREQ-1:0]  REQ_SLEEP_R,
    input  logic [NREQ-1:0]  REQ_MASK_R,
    input  logic             TIMER_EN_R,
    input  logic [CNT_W-1:0] TIMER_LOAD_R,
    input  logic             SL_HALT_ANY_R,
    input  logic             SL_SLEEPSYS_C0_R,
    output logic             EXT_SLEEPREQ_R,
    output logic [NREQ-1:0]  SLEEP_ACK_R,
    output logic             SLEEP_BUSY_R,
    output logic [1:0]       WAKE_CAUSE_R
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);
    localparam logic [1:0] REL_LAST    = 2'(RELEASE_MIN_CYC - 1);

    logic [2:0]      state_q,  state_d;
    logic [3:0]      settle_q, settle_d;
    logic [1:0]      rel_q,    rel_d;
    logic            armed_q,  armed_d;
    logic            ext_q,    ext_d;
    logic [NREQ-1:0] ack_q,    ack_d;
    logic            busy_q,   busy_d;
    logic [1:0]      cause_q,  cause_d;

    logic [NREQ-1:0] act;
    logic            all_req;
    logic            any_drop;
    logic            none_req;
    logic            tmr_load;
    logic            tmr_dec;
    logic            tmr_expired;

    sleep_wake_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (SYSCLKF),
        .rst_n    (RESET_D2_R_N),
        .load     (tmr_load),
        .load_val (TIMER_LOAD_R),
        .dec      (tmr_dec),
        .expired  (tmr_expired)
    );

    assign tmr_dec = (state_q == ST_ASLEEP) && TIMER_EN_R;

    always_comb begin
        act      = ~REQ_MASK_R;
        all_req  = (act != '0) && ((REQ_SLEEP_R & act) == act);
        any_drop = |(act & ~REQ_SLEEP_R);
        none_req = ((REQ_SLEEP_R & act) == '0);

        state_d  = state_q;
        settle_d = settle_q;
        rel_d    = rel_q;
        armed_d  = armed_q;
        cause_d  = cause_q;
        ack_d    = ack_q;
        tmr_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (none_req) begin
                    armed_d = 1'b1;
                end
                if (all_req && armed_q && CFG_SLEEPENABLE) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_INIT;
                end
            end
            ST_SETTLE: begin
                if (!all_req || !CFG_SLEEPENABLE) begin
                    state_d = ST_IDLE;
                end else if (settle_q == '0) begin
                    state_d = ST_REQ;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_REQ: begin
                if (SL_SLEEPSYS_C0_R) begin
                    state_d  = ST_ASLEEP;
                    tmr_load = 1'b1;
                    ack_d    = act;
                    armed_d  = 1'b0;
                end else if (any_drop) begin
                    state_d = ST_RELEASE;
                    cause_d = WC_AGENT;
                end else if (!CFG_SLEEPENABLE) begin
                    state_d = ST_RELEASE;
                    cause_d = WC_DISABLE;
                end
            end
            ST_ASLEEP: begin
                state_d = ST_RELEASE;
                if (!SL_SLEEPSYS_C0_R) begin
                    cause_d = WC_CORE;
                end else if (any_drop) begin
                    cause_d = WC_AGENT;
                end else if (tmr_expired && TIMER_EN_R) begin
                    cause_d = WC_TIMER;
                end else if (!CFG_SLEEPENABLE) begin
                    cause_d = WC_DISABLE;
                end else begin
                    state_d = ST_ASLEEP;
                end
            end
            ST_RELEASE: begin
                // Counter saturates at REL_LAST; the exit test only opens after the minimum hold.
                if (rel_q >= REL_LAST) begin
                    if (!SL_HALT_ANY_R && !SL_SLEEPSYS_C0_R) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    rel_d = rel_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_RELEASE) && (state_q != ST_RELEASE)) begin
            rel_d = '0;
        end
        if (state_d != ST_ASLEEP) begin
            ack_d = '0;
        end
        ext_d  = (state_d == ST_REQ) || (state_d == ST_ASLEEP);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge SYSCLKF or negedge RESET_D2_R_N) begin
        if (!RESET_D2_R_N) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            rel_q    <= '0;
            armed_q  <= 1'b1;
            ext_q    <= 1'b0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            cause_q  <= WC_CORE;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            rel_q    <= rel_d;
            armed_q  <= armed_d;
            ext_q    <= ext_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            cause_q  <= cause_d;
        end
    end

    assign EXT_SLEEPREQ_R = ext_q;
    assign SLEEP_ACK_R    = ack_q;
    assign SLEEP_BUSY_R   = busy_q;
    assign WAKE_CAUSE_R   = cause_q;

endmodule

// File: tb/tb_sleep_req_ctl.sv
// Directed and randomized checks of sleep_req_ctl against a cycle-level
// behavioural model of the request/settle/sleep/release sequence.
module tb_sleep_req_ctl;

    localparam int NREQ   = 4;
    localparam int CNT_W  = 16;
    localparam int SETTLE = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_en;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  mask;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_load;
    logic             halt;
    logic             sys;
    logic             ext;
    logic [NREQ-1:0]  ack;
    logic             busy;
    logic [1:0]       cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sleep_req_ctl #(
        .NREQ       (NREQ),
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .SYSCLKF          (clk),
        .RESET_D2_R_N     (rst_n),
        .CFG_SLEEPENABLE  (cfg_en),
        .REQ_SLEEP_R      (req),
        .REQ_MASK_R       (mask),
        .TIMER_EN_R       (tmr_en),
        .TIMER_LOAD_R     (tmr_load),
        .SL_HALT_ANY_R    (halt),
        .SL_SLEEPSYS_C0_R (sys),
        .EXT_SLEEPREQ_R   (ext),
        .SLEEP_ACK_R      (ack),
        .SLEEP_BUSY_R     (busy),
        .WAKE_CAUSE_R     (cause)
    );

    // Reference model: phase plus elapsed-cycle counters.
    typedef enum int {P_IDLE, P_STABLE, P_REQUEST, P_SLEEP, P_WAKE} phase_t;
    phase_t          ph;
    int              stable_n;
    int              rel_n;
    int              en_n;
    int              m_load;
    bit              m_armed;
    logic [NREQ-1:0] m_ack;
    logic [1:0]      m_cause;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = P_IDLE; stable_n = 0; rel_n = 0; en_n = 0; m_load = 0;
        m_armed = 1'b1; m_ack = '0; m_cause = 2'b00;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] a;
        bit all_r, drop, wake;
        int remaining;
        a     = ~mask;
        all_r = (a != 0) && ((req & a) == a);
        drop  = |(a & ~req);
        case (ph)
            P_IDLE: begin
                if ((req & a) == 0) m_armed = 1'b1;
                if (all_r && m_armed && cfg_en) begin ph = P_STABLE; stable_n = 0; end
            end
            P_STABLE: begin
                if (!all_r || !cfg_en) ph = P_IDLE;
                else begin
                    stable_n++;
                    if (stable_n == SETTLE) ph = P_REQUEST;
                end
            end
            P_REQUEST: begin
                if (sys) begin
                    ph = P_SLEEP; m_ack = a; m_armed = 1'b0; en_n = 0; m_load = int'(tmr_load);
                end else if (drop) begin
                    ph = P_WAKE; rel_n = 0; m_cause = 2'b01;
                end else if (!cfg_en) begin
                    ph = P_WAKE; rel_n = 0; m_cause = 2'b11;
                end
            end
            P_SLEEP: begin
                remaining = (m_load > en_n) ? m_load - en_n : 0;
                wake = 1'b1;
                if (!sys)                           m_cause = 2'b00;
                else if (drop)                      m_cause = 2'b01;
                else if (tmr_en && remaining == 0)  m_cause = 2'b10;
                else if (!cfg_en)                   m_cause = 2'b11;
                else                                wake = 1'b0;
                if (tmr_en) en_n++;
                if (wake) begin ph = P_WAKE; rel_n = 0; m_ack = '0; end
            end
            P_WAKE: begin
                rel_n++;
                if (rel_n >= 3 && !halt && !sys) ph = P_IDLE;
            end
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ext"},   32'(ext),   32'(ph == P_REQUEST || ph == P_SLEEP));
        check({tag, "_ack"},   32'(ack),   32'(m_ack));
        check({tag, "_busy"},  32'(busy),  32'(ph != P_IDLE));
        check({tag, "_cause"}, 32'(cause), 32'(m_cause));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n = 1'b0; cfg_en = 1'b0; req = '0; mask = '0; tmr_en = 1'b0;
        tmr_load = '0; halt = 1'b0; sys = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sleep entry: request 1+SETTLE edges after inputs apply
        cfg_en = 1'b1; req = 4'hF;
        repeat (SETTLE) tick("t1");
        check("t1_ext_early", 32'(ext), 32'd0);
        tick("t1");
        check("t1_ext_rise", 32'(ext), 32'd1);
        sys = 1'b1;
        tick("t1");
        check("t1_ack_all", 32'(ack), 32'hF);
        repeat (3) tick("t1");

        // Agent drop while asleep, halt held in release
        req = 4'b1011;
        tick("t2");
        check("t2_ext_drop", 32'(ext), 32'd0);
        check("t2_ack_drop", 32'(ack), 32'd0);
        check("t2_cause", 32'(cause), 32'd1);
        sys = 1'b0; halt = 1'b1;
        repeat (10) begin
            tick("t2");
            check("t2_busy_halt", 32'(busy), 32'd1);
        end
        halt = 1'b0;
        tick("t2");
        check("t2_busy_done", 32'(busy), 32'd0);

        // Timer wake after LOAD+1 asleep cycles, then re-arm requirement
        req = 4'h0; tick("t3");
        tmr_en = 1'b1; tmr_load = 16'd5; req = 4'hF;
        repeat (SETTLE + 1) tick("t3");
        sys = 1'b1;
        tick("t3");
        repeat (5) begin
            tick("t3");
            check("t3_still_asleep", 32'(ext), 32'd1);
        end
        tick("t3");
        check("t3_timer_wake", 32'(ext), 32'd0);
        check("t3_cause", 32'(cause), 32'd2);
        sys = 1'b0;
        repeat (15) tick("t3");
        check("t3_no_reentry", 32'(busy), 32'd0);
        req = 4'h0; tick("t3");
        req = 4'hF;
        repeat (SETTLE + 1) tick("t3");
        check("t3_resleep", 32'(ext), 32'd1);

        // Disable while requesting: release held exactly 3 cycles when clear
        tmr_en = 1'b0; cfg_en = 1'b0;
        tick("t4");
        check("t4_cause", 32'(cause), 32'd3);
        repeat (2) begin
            tick("t4");
            check("t4_busy_hold", 32'(busy), 32'd1);
        end
        tick("t4");
        check("t4_busy_exit", 32'(busy), 32'd0);
        cfg_en = 1'b1;

        // Partial mask; then core wake (sys falls) gives cause 00
        mask = 4'b0110; req = 4'b1001;
        repeat (SETTLE + 2) tick("t5");
        sys = 1'b1;
        tick("t5");
        check("t5_ack_masked", 32'(ack), 32'h9);
        sys = 1'b0;
        tick("t5");
        check("t5_cause_core", 32'(cause), 32'd0);
        req = 4'h0;
        repeat (5) tick("t5");
        mask = 4'hF; req = 4'hF;
        repeat (30) tick("t5");
        check("t5_all_masked_idle", 32'(busy), 32'd0);

        // Request glitch during settle returns to idle without a request
        mask = 4'h0; req = 4'hF;
        repeat (2) tick("t6");
        req = 4'b1101;
        repeat (SETTLE + 3) begin
            tick("t6");
            check("t6_no_ext", 32'(ext), 32'd0);
        end

        // Asynchronous reset while asleep
        req = 4'h0; tick("t7");
        req = 4'hF;
        repeat (SETTLE + 1) tick("t7");
        sys = 1'b1;
        tick("t7");
        check("t7_asleep", 32'(ext), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("t7_rst_ext", 32'(ext), 32'd0);
        check("t7_rst_ack", 32'(ack), 32'd0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_cause", 32'(cause), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; sys = 1'b0; req = 4'h0;
        tick("t7");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) req = req ^ (4'b0001 << $urandom_range(3));
            if ($urandom_range(39) == 0) req = 4'hF;
            if ($urandom_range(39) == 1) req = 4'h0;
            if ($urandom_range(199) == 0) mask = 4'($urandom_range(15));
            else if ($urandom_range(49) == 0) mask = '0;
            if ($urandom_range(99) == 0) cfg_en = ~cfg_en;
            else if (!cfg_en && $urandom_range(9) == 0) cfg_en = 1'b1;
            if ($urandom_range(2) == 0) sys = (ph == P_REQUEST || ph == P_SLEEP);
            halt = ($urandom_range(2) == 0);
            if ($urandom_range(19) == 0) tmr_en = ~tmr_en;
            tmr_load = 16'($urandom_range(11));
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
